// File: rtl/melody_sequencer.sv
// Note-RAM melody player: steps through 32 {tone, duration} entries on a tick
// prescaler, drives the PWM beeper tone code, and signals end of song.
module melody_sequencer #(
  parameter int TICK_DIV  = 500,
  parameter int GAP_TICKS = 1,
  parameter int MAX_TONE  = 10
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [10:0] wr_data,
  output logic [4:0]  tone,
  output logic        sing_flag,
  output logic        busy,
  output logic [4:0]  note_idx,
  output logic        done
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;
  state_t state;

  logic [10:0]   ram [32];
  logic [PW-1:0] presc;
  logic [5:0]    dur_cnt;

  logic [10:0] rd_entry;
  logic [4:0]  rd_tone;
  logic [4:0]  clamp_tone;
  logic [5:0]  rd_dur;
  logic        tick;
  logic        last_tick;
  logic        advance;
  logic        at_wrap;

  // Asynchronous read: a write landing on the same edge is seen only next cycle.
  assign rd_entry   = ram[note_idx];
  assign rd_tone    = rd_entry[10:6];
  assign rd_dur     = rd_entry[5:0];
  assign clamp_tone = (rd_tone > 5'(MAX_TONE)) ? 5'(MAX_TONE) : rd_tone;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign last_tick = tick && (dur_cnt == 6'd1);
  assign advance   = last_tick && ((state == GAP) || (state == PLAY && GAP_TICKS == 0));
  assign at_wrap   = (note_idx == 5'd31);

  always_ff @(posedge CLK) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      tone      <= 5'd0;
      sing_flag <= 1'b0;
      busy      <= 1'b0;
      note_idx  <= 5'd0;
      done      <= 1'b0;
      presc     <= '0;
      dur_cnt   <= 6'd0;
    end else if (stop) begin
      state     <= IDLE;
      tone      <= 5'd0;
      sing_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            note_idx <= 5'd0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (rd_dur != 6'd0) begin
            state     <= PLAY;
            tone      <= clamp_tone;
            sing_flag <= 1'b1;
            dur_cnt   <= rd_dur;
            presc     <= '0;
          end else if (loop_en && note_idx != 5'd0) begin
            note_idx <= 5'd0;
          end else begin
            state     <= DONE;
            tone      <= 5'd0;
            sing_flag <= 1'b0;
            done      <= 1'b1;
          end
        end
        PLAY, GAP: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) dur_cnt <= dur_cnt - 6'd1;
          if (state == PLAY && last_tick && GAP_TICKS > 0) begin
            state   <= GAP;
            tone    <= 5'd0;
            dur_cnt <= 6'(GAP_TICKS);
            presc   <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Stepping past entry 31 wraps the index; that counts as the end of the song.
      if (advance) begin
        note_idx <= note_idx + 5'd1;
        if (at_wrap && !loop_en) begin
          state     <= DONE;
          tone      <= 5'd0;
          sing_flag <= 1'b0;
          done      <= 1'b1;
        end else begin
          state <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: cycle-accurate vector table on a gapped instance,
// plus hand sequences for async reset and the 32-entry wrap on a gapless one.
module tb_melody_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn, start, stop, loop_en, wr_en;
  logic [4:0]  wr_addr;
  logic [10:0] wr_data;
  logic [4:0]  tone, note_idx, tone0, note_idx0;
  logic        sing_flag, busy, done, sing0, busy0, done0;
  logic [12:0] obs, obs0;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  always #5 CLK = ~CLK;

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .MAX_TONE(10)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tone(tone), .sing_flag(sing_flag), .busy(busy), .note_idx(note_idx), .done(done)
  );

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(0), .MAX_TONE(10)) dut0 (
    .CLK(CLK), .RSTn(RSTn), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tone(tone0), .sing_flag(sing0), .busy(busy0), .note_idx(note_idx0), .done(done0)
  );

  assign obs  = {tone, sing_flag, busy, done, note_idx};
  assign obs0 = {tone0, sing0, busy0, done0, note_idx0};

  typedef struct {
    int          n;
    logic        st, sp, lp, we;
    logic [4:0]  wa;
    logic [10:0] wd;
    logic [4:0]  tone;
    logic        sing, busy, done;
    logic [4:0]  idx;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [10:0] ent(int t, int d);
    return {5'(t), 6'(d)};
  endfunction

  function automatic void add(int n, int st, int sp, int lp, int t, int s, int b, int d, int i,
                              int we = 0, int wa = 0, logic [10:0] wd = 11'd0);
    vec_t v;
    v.n = n; v.st = 1'(st); v.sp = 1'(sp); v.lp = 1'(lp); v.we = 1'(we);
    v.wa = 5'(wa); v.wd = wd; v.tone = 5'(t); v.sing = 1'(s); v.busy = 1'(b);
    v.done = 1'(d); v.idx = 5'(i);
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic step0();
    step();
    if (busy0) busy_cnt++;
  endtask

  task automatic check(string name, logic [12:0] act, logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got tone=%0d sing=%0d busy=%0d done=%0d idx=%0d, want tone=%0d sing=%0d busy=%0d done=%0d idx=%0d",
               name, act[12:8], act[7], act[6], act[5], act[4:0],
               exp[12:8], exp[7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  task automatic check_n(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic write(int a, logic [10:0] d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 11'd0;
    #12 RSTn = 1'b1;

    // n, start, stop, loop, tone, sing, busy, done, idx [, we, wa, wd]
    add(2, 0,0,0, 0,0,0,0,0);
    // three-entry song with a gap after each note
    add(1, 0,0,0, 0,0,0,0,0, 1,0,ent(5,2));
    add(1, 0,0,0, 0,0,0,0,0, 1,1,ent(0,3));
    add(1, 0,0,0, 0,0,0,0,0, 1,2,ent(0,0));
    add(1, 1,0,0, 0,0,1,0,0);
    add(3, 0,0,0, 5,1,1,0,0);
    add(1, 1,0,0, 5,1,1,0,0);
    add(4, 0,0,0, 5,1,1,0,0);
    add(4, 0,0,0, 0,1,1,0,0);
    add(1, 0,0,0, 0,1,1,0,1);
    add(12,0,0,0, 0,1,1,0,1);
    add(4, 0,0,0, 0,1,1,0,1);
    add(1, 0,0,0, 0,1,1,0,2);
    add(1, 0,0,0, 0,0,1,1,2);
    add(2, 0,0,0, 0,0,0,0,2);
    // tone clamp: 11 clamps to 10, 9 passes through
    add(1, 0,0,0, 0,0,0,0,2, 1,0,ent(11,1));
    add(1, 0,0,0, 0,0,0,0,2, 1,1,ent(9,1));
    add(1, 1,0,0, 0,0,1,0,0);
    add(4, 0,0,0, 10,1,1,0,0);
    add(4, 0,0,0, 0,1,1,0,0);
    add(1, 0,0,0, 0,1,1,0,1);
    add(4, 0,0,0, 9,1,1,0,1);
    add(4, 0,0,0, 0,1,1,0,1);
    add(1, 0,0,0, 0,1,1,0,2);
    add(1, 0,0,0, 0,0,1,1,2);
    add(1, 0,0,0, 0,0,0,0,2);
    // looping two-note song, entry 0 rewritten mid-play, then stop
    add(1, 0,0,1, 0,0,0,0,2, 1,0,ent(3,1));
    add(1, 0,0,1, 0,0,0,0,2, 1,1,ent(4,1));
    add(1, 1,0,1, 0,0,1,0,0);
    add(4, 0,0,1, 3,1,1,0,0);
    add(4, 0,0,1, 0,1,1,0,0, 1,0,ent(7,1));
    add(1, 0,0,1, 0,1,1,0,1);
    add(4, 0,0,1, 4,1,1,0,1);
    add(4, 0,0,1, 0,1,1,0,1);
    add(1, 0,0,1, 0,1,1,0,2);
    add(1, 0,0,1, 0,1,1,0,0);
    add(4, 0,0,1, 7,1,1,0,0);
    add(4, 0,0,1, 0,1,1,0,0);
    add(1, 0,0,1, 0,1,1,0,1);
    add(2, 0,0,1, 4,1,1,0,1);
    add(1, 0,1,1, 0,0,0,0,1);
    add(2, 0,0,1, 0,0,0,0,1);
    // end marker at entry 0 with looping: straight to DONE
    add(1, 0,0,1, 0,0,0,0,1, 1,0,ent(4,0));
    add(1, 1,0,1, 0,0,1,0,0);
    add(1, 0,0,1, 0,0,1,1,0);
    add(2, 0,0,1, 0,0,0,0,0);
    // start and stop together: stays idle
    add(1, 1,1,0, 0,0,0,0,0);
    add(2, 0,0,0, 0,0,0,0,0);

    foreach (vecs[r]) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        start = vecs[r].st; stop = vecs[r].sp; loop_en = vecs[r].lp;
        wr_en = vecs[r].we; wr_addr = vecs[r].wa; wr_data = vecs[r].wd;
        step();
        check($sformatf("row%0d.%0d", r, c), obs,
              {vecs[r].tone, vecs[r].sing, vecs[r].busy, vecs[r].done, vecs[r].idx});
      end
    end
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; wr_en = 1'b0;

    // asynchronous reset in the middle of the second note
    write(0, ent(6,1));
    write(1, ent(6,3));
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    check("pre_reset", obs, {5'd6, 1'b1, 1'b1, 1'b0, 5'd1});
    #3 RSTn = 1'b0;
    #1;
    check("async_reset", obs, 13'd0);
    check("async_reset_nogap", obs0, 13'd0);
    #2 RSTn = 1'b1;
    step();
    check("post_reset", obs, 13'd0);

    // all 32 entries of duration 1 on the gapless instance
    for (int i = 0; i < 32; i++) write(i, ent(i % 8, 1));
    busy_cnt = 0;
    start = 1'b1;
    step0();
    start = 1'b0;
    check("wrap_fetch0", obs0, {5'd0, 1'b0, 1'b1, 1'b0, 5'd0});
    for (int i = 0; i < 32; i++) begin
      step0();
      check($sformatf("wrap_play%0d", i), obs0, {5'(i % 8), 1'b1, 1'b1, 1'b0, 5'(i)});
      repeat (3) step0();
      if (i < 31) begin
        step0();
        check($sformatf("wrap_fetch%0d", i + 1), obs0, {5'(i % 8), 1'b1, 1'b1, 1'b0, 5'(i + 1)});
      end
    end
    step0();
    check("wrap_done", obs0, {5'd0, 1'b0, 1'b1, 1'b1, 5'd0});
    step0();
    check("wrap_idle", obs0, {5'd0, 1'b0, 1'b0, 1'b0, 5'd0});
    check_n("busy_cycles", busy_cnt, 32 + 32 * 4 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
